// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding and the
// ID-width helper, reusable by other timer/irq blocks.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

    // A single source still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational priority pick: first set bit of req, searching upward from
// offset and wrapping modulo NUM_SRC.
module irq_prio_pick #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    offset,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = (int'(offset) + k) % NUM_SRC;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, per-source mask, sticky overflow,
// and an IDLE/ACTIVE/GAP handshake. Define IRQ_ARBITER_ROUND_ROBIN_EN for rotating priority.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int                 NUM_SRC    = 4,
    parameter int                 ID_W       = id_width(NUM_SRC),
    parameter logic [NUM_SRC-1:0] MASK_RESET = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic [NUM_SRC-1:0] ovf_clr,
    input  logic               irq_ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] overflow_o
);

    logic [NUM_SRC-1:0] src_prev, pending, overflow, mask;
    logic [NUM_SRC-1:0] rise, clr, ovf_set;
    logic [ID_W-1:0]    offset, pick_idx;
    logic               pick_found, ack_ok;
    irq_state_e         state;

    // Handshake: irq_out/irq_id are held until an irq_ack is seen while ACTIVE
    // and enabled; that cycle consumes the grant. Acks at any other time are dropped.
    assign ack_ok  = enable && (state == ST_ACTIVE) && irq_ack;
    assign rise    = src_irq & ~src_prev;
    assign ovf_set = enable ? (rise & pending & ~clr) : '0;

    always_comb begin
        clr = '0;
        if (ack_ok) clr[irq_id] = 1'b1;
    end

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    assign offset = (rr_ptr == ID_W'(NUM_SRC - 1)) ? '0 : rr_ptr + ID_W'(1);

    // Pointer starts at the last index so the first search begins at 0.
    always_ff @(posedge clk) begin
        if (!rst_n)      rr_ptr <= ID_W'(NUM_SRC - 1);
        else if (ack_ok) rr_ptr <= irq_id;
    end
`else
    assign offset = '0;
`endif

    irq_prio_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (pending & mask),
        .offset (offset),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_prev <= '0;
            pending  <= '0;
            overflow <= '0;
            mask     <= MASK_RESET;
            state    <= ST_IDLE;
            irq_out  <= 1'b0;
            irq_id   <= '0;
        end else begin
            src_prev <= src_irq;
            // A rise on the source being cleared re-arms it rather than overflowing.
            if (enable) pending <= (pending & ~clr) | rise;
            overflow <= (overflow & ~ovf_clr) | ovf_set;
            if (mask_we) mask <= mask_wdata;

            if (!enable) begin
                state   <= ST_IDLE;
                irq_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pick_found) begin
                            irq_id  <= pick_idx;
                            state   <= ST_ACTIVE;
                            irq_out <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (irq_ack) begin
                            state   <= ST_GAP;
                            irq_out <= 1'b0;
                        end
                    end
                    ST_GAP: state <= ST_IDLE;
                    default: begin
                        state   <= ST_IDLE;
                        irq_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pending_o  = pending;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter (NUM_SRC=4): directed vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, enable, mask_we, irq_ack;
    logic [3:0] src_irq, mask_wdata, ovf_clr;
    logic       irq_out;
    logic [1:0] irq_id;
    logic [3:0] pending_o, overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_arbiter #(
        .NUM_SRC    (4),
        .ID_W       (2),
        .MASK_RESET (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ovf_clr    (ovf_clr),
        .irq_ack    (irq_ack),
        .irq_out    (irq_out),
        .irq_id     (irq_id),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    // Reference model: pending/overflow/mask as bit sets, the grant as a phase
    // number (0 waiting, 1 presenting, 2 one-cycle cooldown) plus granted index.
    logic [3:0] m_pend, m_ovf, m_mask, m_prev;
    int         m_phase, m_id, m_last;

    function automatic int m_pick();
        int start;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        start = (m_last + 1) % 4;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (m_pend[i] && m_mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] rise, clr, oset;
        int win;
        if (!rst_n) begin
            m_pend = 0; m_ovf = 0; m_mask = 4'hF; m_prev = 0;
            m_phase = 0; m_id = 0; m_last = 3;
        end else begin
            rise = src_irq & ~m_prev;
            clr  = 0;
            if (enable && m_phase == 1 && irq_ack) clr[m_id] = 1'b1;
            win  = m_pick();
            oset = 0;
            if (enable) begin
                oset   = rise & m_pend & ~clr;
                m_pend = (m_pend & ~clr) | rise;
            end
            m_ovf = (m_ovf & ~ovf_clr) | oset;
            if (!enable) m_phase = 0;
            else if (m_phase == 0) begin
                if (win >= 0) begin m_id = win; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (irq_ack) begin m_last = m_id; m_phase = 2; end
            end else m_phase = 0;
            if (mask_we) m_mask = mask_wdata;
            m_prev = src_irq;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b1; src_irq = 0; mask_we = 0; mask_wdata = 0; ovf_clr = 0; irq_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] src;
        logic       mwe;
        logic [3:0] mwd;
        logic [3:0] oclr;
        logic       ack;
        logic       en;
        logic       eirq;
        logic [1:0] eid;
        logic [3:0] epend;
        logic [3:0] eovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                       input logic [3:0] oclr, input logic ack, input logic en,
                       input logic eirq, input logic [1:0] eid,
                       input logic [3:0] epend, input logic [3:0] eovf);
        vec_t v;
        v.src = src; v.mwe = mwe; v.mwd = mwd; v.oclr = oclr; v.ack = ack; v.en = en;
        v.eirq = eirq; v.eid = eid; v.epend = epend; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    logic [1:0] exp_q[$];

    initial begin
        // Table: each row is one clock; expectations are the outputs after that edge.
        //   src   mwe mwd   oclr ack en   irq id pend  ovf
        add(4'ha, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'ha, 4'h0); // two sources at once
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 1, 4'ha, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 1, 4'h8, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 1, 4'h8, 4'h0); // gap -> idle
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 3, 4'h8, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 3, 4'h0, 4'h0);
        add(4'h4, 0, 4'h0, 4'h0, 0, 1,   0, 3, 4'h4, 4'h0); // single pulse on src 2
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 2, 4'h4, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 2, 4'h0, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 2, 4'h0, 4'h0);
        add(4'h1, 0, 4'h0, 4'h0, 0, 1,   0, 2, 4'h1, 4'h0); // overflow on src 0
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h0);
        add(4'h1, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h1);
        add(4'h0, 0, 4'h0, 4'h1, 0, 1,   1, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 0, 4'h0, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h0, 4'h0);
        add(4'h1, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0); // set+clear same cycle
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h0);
        add(4'h1, 0, 4'h0, 4'h0, 1, 1,   0, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 0, 4'h0, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h0, 4'h0);
        add(4'h0, 1, 4'he, 4'h0, 0, 1,   0, 0, 4'h0, 4'h0); // mask src 0
        add(4'h1, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0);
        add(4'h0, 1, 4'hf, 4'h0, 0, 1,   0, 0, 4'h1, 4'h0); // unmask, seen next cycle
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 0,   0, 0, 4'h1, 4'h0); // disable while active
        add(4'h2, 0, 4'h0, 4'h0, 0, 0,   0, 0, 4'h1, 4'h0); // rise ignored when disabled
        add(4'h2, 0, 4'h0, 4'h0, 0, 1,   1, 0, 4'h1, 4'h0); // held level: no new rise
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 0, 4'h0, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h0, 4'h0);
        add(4'h8, 0, 4'h0, 4'h0, 0, 1,   0, 0, 4'h8, 4'h0); // mask the active source
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 3, 4'h8, 4'h0);
        add(4'h0, 1, 4'h7, 4'h0, 0, 1,   1, 3, 4'h8, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 0, 1,   1, 3, 4'h8, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 1, 1,   0, 3, 4'h0, 4'h0);

        // Reset values
        do_reset();
        chk("reset_irq_out", irq_out, 0);
        chk("reset_irq_id", irq_id, 0);
        chk("reset_pending", pending_o, 0);
        chk("reset_overflow", overflow_o, 0);

        foreach (tbl[r]) begin
            src_irq = tbl[r].src; mask_we = tbl[r].mwe; mask_wdata = tbl[r].mwd;
            ovf_clr = tbl[r].oclr; irq_ack = tbl[r].ack; enable = tbl[r].en;
            tick();
            chk($sformatf("tbl%0d_irq_out", r), irq_out, tbl[r].eirq);
            if (tbl[r].eirq) chk($sformatf("tbl%0d_irq_id", r), irq_id, tbl[r].eid);
            chk($sformatf("tbl%0d_pending", r), pending_o, tbl[r].epend);
            chk($sformatf("tbl%0d_overflow", r), overflow_o, tbl[r].eovf);
        end

        // Reset in the middle of an active grant
        do_reset();
        src_irq = 4'h4; tick();
        src_irq = 4'h0; tick();
        chk("midrst_active", irq_out, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_irq_out", irq_out, 0);
        chk("midrst_irq_id", irq_id, 0);
        chk("midrst_pending", pending_o, 0);
        chk("midrst_overflow", overflow_o, 0);

        // All sources pending, acked source re-pulsed after every ack
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        do_reset();
        src_irq = 4'hf; tick();
        src_irq = 4'h0;
        for (int g = 0; g < 5; g++) begin
            for (int w = 0; w < 10 && !irq_out; w++) tick();
            chk($sformatf("rot%0d_irq_out", g), irq_out, 1);
            chk($sformatf("rot%0d_irq_id", g), irq_id, exp_q.pop_front());
            irq_ack = 1'b1; tick();
            irq_ack = 1'b0;
            chk($sformatf("rot%0d_gap", g), irq_out, 0);
            src_irq = 4'hf; tick();
            src_irq = 4'h0;
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom_range(0, 249) != 0);
            enable     = ($urandom_range(0, 9) != 0);
            src_irq    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            irq_ack    = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            ovf_clr    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            tick();
            chk("rnd_irq_out", irq_out, (m_phase == 1));
            chk("rnd_irq_id", irq_id, m_id[1:0]);
            chk("rnd_pending", pending_o, m_pend);
            chk("rnd_overflow", overflow_o, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
